// File: rtl/lidar_frame_parser_if.sv
`default_nettype none
// ============================================================================
// lidar_frame_parser_if : byte stream in, validated LiDAR payload and status out
// Rev 1.0
// ============================================================================
interface lidar_frame_parser_if #(
  parameter int PAYLOAD_BYTES = 6
);
  logic [7:0]                 byte_in;
  logic                       byte_valid_in;
  logic [8*PAYLOAD_BYTES-1:0] payload_out;
  logic                       frame_valid_out;
  logic                       checksum_err_out;
  logic                       timeout_out;
  logic [15:0]                frame_count_out;
  logic [15:0]                err_count_out;

  modport master (
    output byte_in, byte_valid_in,
    input  payload_out, frame_valid_out, checksum_err_out, timeout_out,
           frame_count_out, err_count_out
  );

  modport slave (
    input  byte_in, byte_valid_in,
    output payload_out, frame_valid_out, checksum_err_out, timeout_out,
           frame_count_out, err_count_out
  );
endinterface
`default_nettype wire

// File: rtl/lidar_frame_parser.sv
`default_nettype none
// ============================================================================
// lidar_frame_parser : header lock, payload capture, additive checksum check,
//                      inter-byte timeout and frame/error accounting
// Rev 1.0
// ============================================================================
module lidar_frame_parser #(
  parameter logic [7:0] HEADER_BYTE    = 8'h59,
  parameter int         HEADER_COUNT   = 2,
  parameter int         PAYLOAD_BYTES  = 6,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  wire logic           clk_in,
  input  wire logic           rst_in,
  lidar_frame_parser_if.slave bus
);

  localparam int HDR_W = $clog2(HEADER_COUNT + 1);
  localparam int IDX_W = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int PW    = 8 * PAYLOAD_BYTES;

  localparam logic [HDR_W-1:0] HDR_LAST = HDR_W'(HEADER_COUNT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAYLOAD_BYTES - 1);
  localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2,
    CHECK   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        sum_q, sum_d;
  logic [HDR_W-1:0]  hdr_cnt_q, hdr_cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [TO_W-1:0]   idle_q, idle_d;
  logic [PW-1:0]     shadow_q, shadow_d;
  logic [PW-1:0]     payload_q, payload_d;
  logic              frame_valid_q, frame_valid_d;
  logic              checksum_err_q, checksum_err_d;
  logic              timeout_q, timeout_d;
  logic [15:0]       frame_count_q, frame_count_d;
  logic [15:0]       err_count_q, err_count_d;

  logic [15:0]       err_count_inc;

  assign err_count_inc = (err_count_q == 16'hFFFF) ? err_count_q : err_count_q + 16'd1;

  always_comb begin
    state_d        = state_q;
    sum_d          = sum_q;
    hdr_cnt_d      = hdr_cnt_q;
    idx_d          = idx_q;
    idle_d         = idle_q;
    shadow_d       = shadow_q;
    payload_d      = payload_q;
    frame_valid_d  = 1'b0;
    checksum_err_d = 1'b0;
    timeout_d      = 1'b0;
    frame_count_d  = frame_count_q;
    err_count_d    = err_count_q;

    if (bus.byte_valid_in) begin
      // A byte in the expiry cycle wins over the timeout.
      idle_d = '0;
      case (state_q)
        HUNT: begin
          if (bus.byte_in == HEADER_BYTE) begin
            sum_d     = bus.byte_in;
            hdr_cnt_d = HDR_W'(1);
            idx_d     = '0;
            state_d   = (HEADER_COUNT == 1) ? PAYLOAD : HEADER;
          end
        end
        HEADER: begin
          if (bus.byte_in == HEADER_BYTE) begin
            sum_d     = sum_q + bus.byte_in;
            hdr_cnt_d = hdr_cnt_q + HDR_W'(1);
            if (hdr_cnt_q == HDR_LAST) state_d = PAYLOAD;
          end else begin
            state_d   = HUNT;
            sum_d     = '0;
            hdr_cnt_d = '0;
          end
        end
        PAYLOAD: begin
          for (int i = 0; i < PAYLOAD_BYTES; i++) begin
            if (idx_q == IDX_W'(i)) shadow_d[8*i +: 8] = bus.byte_in;
          end
          sum_d = sum_q + bus.byte_in;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = CHECK;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
          end
        end
        default: begin
          if (bus.byte_in == sum_q) begin
            payload_d     = shadow_q;
            frame_valid_d = 1'b1;
            frame_count_d = frame_count_q + 16'd1;
          end else begin
            checksum_err_d = 1'b1;
            err_count_d    = err_count_inc;
          end
          state_d   = HUNT;
          sum_d     = '0;
          idx_d     = '0;
          hdr_cnt_d = '0;
        end
      endcase
    end else if (state_q == HUNT) begin
      idle_d = '0;
    end else if (idle_q == TO_MAX) begin
      timeout_d   = 1'b1;
      err_count_d = err_count_inc;
      state_d     = HUNT;
      idle_d      = '0;
      sum_d       = '0;
      idx_d       = '0;
      hdr_cnt_d   = '0;
    end else begin
      idle_d = idle_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q        <= HUNT;
      sum_q          <= '0;
      hdr_cnt_q      <= '0;
      idx_q          <= '0;
      idle_q         <= '0;
      shadow_q       <= '0;
      payload_q      <= '0;
      frame_valid_q  <= 1'b0;
      checksum_err_q <= 1'b0;
      timeout_q      <= 1'b0;
      frame_count_q  <= '0;
      err_count_q    <= '0;
    end else begin
      state_q        <= state_d;
      sum_q          <= sum_d;
      hdr_cnt_q      <= hdr_cnt_d;
      idx_q          <= idx_d;
      idle_q         <= idle_d;
      shadow_q       <= shadow_d;
      payload_q      <= payload_d;
      frame_valid_q  <= frame_valid_d;
      checksum_err_q <= checksum_err_d;
      timeout_q      <= timeout_d;
      frame_count_q  <= frame_count_d;
      err_count_q    <= err_count_d;
    end
  end

  assign bus.payload_out      = payload_q;
  assign bus.frame_valid_out  = frame_valid_q;
  assign bus.checksum_err_out = checksum_err_q;
  assign bus.timeout_out      = timeout_q;
  assign bus.frame_count_out  = frame_count_q;
  assign bus.err_count_out    = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_lidar_frame_parser.sv
`default_nettype none
// ============================================================================
// tb_lidar_frame_parser : directed frames with hand-computed results
// Rev 1.0
// ============================================================================
module tb_lidar_frame_parser;

  localparam logic [47:0] P_F1 = 48'h0900_2710_012C;  // checksum 1F
  localparam logic [47:0] P_F2 = 48'h0605_0403_0201;  // checksum C7
  localparam logic [47:0] P_F3 = 48'h0900_2710_5959;  // checksum A4

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_bad    = 0;

  lidar_frame_parser_if #(.PAYLOAD_BYTES(6)) bus ();

  lidar_frame_parser #(
    .HEADER_BYTE   (8'h59),
    .HEADER_COUNT  (2),
    .PAYLOAD_BYTES (6),
    .TIMEOUT_CYCLES(10)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    bus.byte_in       = b;
    bus.byte_valid_in = 1'b1;
    @(posedge clk);
    #1;
    bus.byte_valid_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [47:0] pl, input logic [7:0] ck);
    send(8'h59);
    send(8'h59);
    for (int i = 0; i < 6; i++) send(pl[8*i +: 8]);
    send(ck);
  endtask

  initial begin
    bus.byte_in       = 8'h00;
    bus.byte_valid_in = 1'b0;
    idle(3);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_payload", 64'(bus.payload_out), 64'h0);
    chk("rst_fcount",  64'(bus.frame_count_out), 64'h0);
    chk("rst_ecount",  64'(bus.err_count_out), 64'h0);
    chk("rst_pulses",  64'({bus.frame_valid_out, bus.checksum_err_out, bus.timeout_out}), 64'h0);

    send_frame(P_F1, 8'h1F);
    chk("f1_valid",   64'(bus.frame_valid_out), 64'h1);
    chk("f1_payload", 64'(bus.payload_out), 64'(P_F1));
    chk("f1_fcount",  64'(bus.frame_count_out), 64'h1);
    idle(1);
    chk("f1_pulse_end", 64'(bus.frame_valid_out), 64'h0);

    send_frame(P_F2, 8'hC8);
    chk("bad_err",     64'(bus.checksum_err_out), 64'h1);
    chk("bad_valid",   64'(bus.frame_valid_out), 64'h0);
    chk("bad_ecount",  64'(bus.err_count_out), 64'h1);
    chk("bad_hold",    64'(bus.payload_out), 64'(P_F1));

    send_frame(P_F2, 8'hC7);
    chk("f2_valid",   64'(bus.frame_valid_out), 64'h1);
    chk("f2_payload", 64'(bus.payload_out), 64'(P_F2));
    chk("f2_fcount",  64'(bus.frame_count_out), 64'h2);

    send(8'h00);
    send(8'h59);
    send(8'h12);
    send_frame(P_F1, 8'h1F);
    chk("gar_valid",   64'(bus.frame_valid_out), 64'h1);
    chk("gar_payload", 64'(bus.payload_out), 64'(P_F1));
    chk("gar_fcount",  64'(bus.frame_count_out), 64'h3);
    chk("gar_ecount",  64'(bus.err_count_out), 64'h1);

    send_frame(P_F3, 8'hA4);
    chk("hdr_in_pl_valid", 64'(bus.frame_valid_out), 64'h1);
    chk("hdr_in_pl_dist",  64'(bus.payload_out[15:0]), 64'h5959);
    chk("hdr_in_pl_fcnt",  64'(bus.frame_count_out), 64'h4);

    // Abandon after the idle count reaches 10.
    send(8'h59);
    send(8'h59);
    send(8'h2C);
    idle(10);
    chk("to_not_yet", 64'(bus.timeout_out), 64'h0);
    idle(1);
    chk("to_pulse",  64'(bus.timeout_out), 64'h1);
    chk("to_ecount", 64'(bus.err_count_out), 64'h2);
    idle(1);
    chk("to_pulse_end", 64'(bus.timeout_out), 64'h0);
    send_frame(P_F1, 8'h1F);
    chk("to_resync_valid", 64'(bus.frame_valid_out), 64'h1);
    chk("to_resync_fcnt",  64'(bus.frame_count_out), 64'h5);

    // Byte lands in the expiry cycle: frame continues.
    send(8'h59);
    send(8'h59);
    send(8'h2C);
    idle(10);
    send(8'h01);
    chk("exp_no_to", 64'(bus.timeout_out), 64'h0);
    send(8'h10);
    send(8'h27);
    send(8'h00);
    send(8'h09);
    send(8'h1F);
    chk("exp_valid",  64'(bus.frame_valid_out), 64'h1);
    chk("exp_fcount", 64'(bus.frame_count_out), 64'h6);
    chk("exp_ecount", 64'(bus.err_count_out), 64'h2);

    @(negedge clk);
    force dut.frame_count_q = 16'hFFFE;
    @(negedge clk);
    release dut.frame_count_q;
    @(posedge clk);
    #1;
    send_frame(P_F1, 8'h1F);
    chk("wrap_ffff", 64'(bus.frame_count_out), 64'hFFFF);
    send_frame(P_F2, 8'hC7);
    chk("wrap_valid",   64'(bus.frame_valid_out), 64'h1);
    chk("wrap_zero",    64'(bus.frame_count_out), 64'h0);
    chk("wrap_payload", 64'(bus.payload_out), 64'(P_F2));

    @(negedge clk);
    force dut.err_count_q = 16'hFFFE;
    @(negedge clk);
    release dut.err_count_q;
    @(posedge clk);
    #1;
    send_frame(P_F1, 8'h00);
    chk("sat_err1",   64'(bus.checksum_err_out), 64'h1);
    chk("sat_ffff1",  64'(bus.err_count_out), 64'hFFFF);
    send_frame(P_F1, 8'h00);
    chk("sat_err2",   64'(bus.checksum_err_out), 64'h1);
    chk("sat_ffff2",  64'(bus.err_count_out), 64'hFFFF);

    send(8'h59);
    send(8'h59);
    send(8'h2C);
    send(8'h01);
    send(8'h10);
    rst = 1'b1;
    #2;
    chk("mid_rst_payload", 64'(bus.payload_out), 64'h0);
    chk("mid_rst_fcount",  64'(bus.frame_count_out), 64'h0);
    chk("mid_rst_ecount",  64'(bus.err_count_out), 64'h0);
    chk("mid_rst_pulses",  64'({bus.frame_valid_out, bus.checksum_err_out, bus.timeout_out}), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    send_frame(P_F1, 8'h1F);
    chk("post_rst_valid",   64'(bus.frame_valid_out), 64'h1);
    chk("post_rst_payload", 64'(bus.payload_out), 64'(P_F1));
    chk("post_rst_fcount",  64'(bus.frame_count_out), 64'h1);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
